// File: rtl/egd_stream_decoder.sv
// Exp-Golomb / fixed-length syntax element decoder with an MSB-first bit buffer.
// Optional performance counters (sym_count, err_count) are built when EGD_PERF_CNT_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a request (and for the previous result to drain)
// S_LZ   | counting leading zeros of an exp-Golomb code
// S_INFO | shifting in info bits (exp-Golomb suffix, u(n) or short te)
// S_DONE | zero-length element; publishes a 0 result on the next edge
module egd_stream_decoder #(
  parameter int IN_W  = 16,
  parameter int BUF_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_mode,
  input  logic [$clog2(OUT_W+1)-1:0]   req_len,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_err,
  output logic [$clog2(BUF_W+1)-1:0]   fill_level,
  output logic                         busy
`ifdef EGD_PERF_CNT_EN
  ,
  output logic [15:0]                  sym_count,
  output logic [7:0]                   err_count
`endif
);

  localparam int LEN_W  = $clog2(OUT_W+1);
  localparam int FILL_W = $clog2(BUF_W+1);

  localparam logic [1:0] MODE_UE = 2'b00;
  localparam logic [1:0] MODE_SE = 2'b01;
  localparam logic [1:0] MODE_TE = 2'b10;
  localparam logic [1:0] MODE_U  = 2'b11;

  generate
    if (BUF_W < IN_W) begin : g_bad_buf_w
      $error("egd_stream_decoder: BUF_W must be >= IN_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_LZ, S_INFO, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [1:0]           mode_q, mode_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     m_q, m_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     info_q, info_d;

  logic                 have_bit, cur_bit, consume, push, req_fire, te_short;
  logic                 finish, fin_err;
  logic [OUT_W-1:0]     fin_val, info_nxt, pow_m, code_nxt;
  logic [LEN_W-1:0]     len_clamp;
  logic [FILL_W-1:0]    fill_after;
  logic [BUF_W-1:0]     buf_shift, word_ext;

  function automatic logic [OUT_W-1:0] map_code(input logic [1:0] mode, input logic [OUT_W-1:0] code);
    logic [OUT_W-1:0] half;
    half = code >> 1;
    if (mode == MODE_SE)
      map_code = code[0] ? half + OUT_W'(1) : '0 - half;
    else
      map_code = code;
  endfunction

  assign have_bit   = (fill_q != '0);
  assign cur_bit    = buf_q[BUF_W-1];
  assign in_ready   = (fill_q <= FILL_W'(BUF_W-IN_W));
  assign req_ready  = (state_q == S_IDLE) && !out_valid;
  assign req_fire   = req_valid && req_ready;
  assign push       = in_valid && in_ready;
  assign busy       = (state_q != S_IDLE);
  assign fill_level = fill_q;
  assign len_clamp  = (req_len > LEN_W'(OUT_W)) ? LEN_W'(OUT_W) : req_len;
  assign te_short   = (mode_q == MODE_TE) && (len_q == LEN_W'(1));
  assign info_nxt   = {info_q[OUT_W-2:0], cur_bit};
  assign pow_m      = OUT_W'(1) << m_q;
  assign code_nxt   = pow_m - OUT_W'(1) + info_nxt;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    info_d  = info_q;
    consume = 1'b0;
    finish  = 1'b0;
    fin_err = 1'b0;
    fin_val = '0;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          mode_d = req_mode;
          len_d  = len_clamp;
          m_d    = '0;
          info_d = '0;
          if (req_mode == MODE_U) begin
            if (len_clamp == '0) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = len_clamp;
              state_d = S_INFO;
            end
          end else if (req_mode == MODE_TE && len_clamp == LEN_W'(1)) begin
            cnt_d   = LEN_W'(1);
            state_d = S_INFO;
          end else begin
            state_d = S_LZ;
          end
        end
      end
      S_LZ: begin
        if (have_bit) begin
          consume = 1'b1;
          if (!cur_bit) begin
            // The OUT_W-th zero can no longer be represented: abort with an error.
            if (m_q == LEN_W'(OUT_W-1)) begin
              finish  = 1'b1;
              fin_err = 1'b1;
              state_d = S_IDLE;
            end else begin
              m_d = m_q + LEN_W'(1);
            end
          end else if (m_q == '0) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = m_q;
            info_d  = '0;
            state_d = S_INFO;
          end
        end
      end
      S_INFO: begin
        if (have_bit) begin
          consume = 1'b1;
          info_d  = info_nxt;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            finish  = 1'b1;
            state_d = S_IDLE;
            if (mode_q == MODE_U)
              fin_val = info_nxt;
            else if (te_short)
              fin_val = {{(OUT_W-1){1'b0}}, ~cur_bit};
            else
              fin_val = map_code(mode_q, code_nxt);
          end
        end
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // New words land directly behind the last valid bit left after this cycle's consume.
  always_comb begin
    buf_shift  = consume ? {buf_q[BUF_W-2:0], 1'b0} : buf_q;
    fill_after = fill_q - FILL_W'(consume);
    word_ext   = '0;
    word_ext[BUF_W-1 -: IN_W] = in_data;
    buf_d  = push ? (buf_shift | (word_ext >> fill_after)) : buf_shift;
    fill_d = fill_after + (push ? FILL_W'(IN_W) : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      fill_q  <= '0;
      mode_q  <= MODE_UE;
      len_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      info_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      info_q  <= info_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (finish) begin
      out_valid <= 1'b1;
      out_data  <= fin_val;
      out_err   <= fin_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef EGD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_count <= '0;
      err_count <= '0;
    end else if (out_valid && out_ready) begin
      if (sym_count != '1)
        sym_count <= sym_count + 16'd1;
      if (out_err && err_count != '1)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_egd_stream_decoder.sv
// Directed and randomized checks of egd_stream_decoder against a bit-queue reference model.
module tb_egd_stream_decoder;
  localparam int IN_W  = 16;
  localparam int BUF_W = 32;
  localparam int OUT_W = 16;

  logic        clk, reset_n;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic        req_valid, req_ready;
  logic [1:0]  req_mode;
  logic [4:0]  req_len;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_err;
  logic [5:0]  fill_level;
  logic        busy;

  egd_stream_decoder #(.IN_W(IN_W), .BUF_W(BUF_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_len(req_len),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .fill_level(fill_level), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit          mstream[$];
  logic [15:0] src[$];
  int pushed_bits   = 0;
  int consumed_bits = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_word(input logic [15:0] w, input bit to_src);
    for (int i = 15; i >= 0; i--) mstream.push_back(w[i]);
    if (to_src) src.push_back(w);
  endtask

  task automatic step_pump();
    in_valid = (src.size() > 0) && in_ready;
    in_data  = (src.size() > 0) ? src[0] : 16'h0;
    @(posedge clk);
    if (in_valid) begin
      void'(src.pop_front());
      pushed_bits += IN_W;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (src.size() > 0 && guard < 50) begin
      step_pump();
      guard++;
    end
  endtask

  // Reference: decode one element straight from the stream's bit sequence.
  task automatic model_decode(input logic [1:0] mode, input int len, output int val,
                              output bit err, output int need, output int lat);
    int n, m, info, code;
    bit b;
    val = 0; err = 0; need = 0; lat = 1;
    if (mode == 2'b11) begin
      n = (len > OUT_W) ? OUT_W : len;
      for (int i = 0; i < n; i++) val = val * 2 + int'(mstream.pop_front());
      need = n;
      lat  = (n == 0) ? 1 : n;
    end else if (mode == 2'b10 && len == 1) begin
      val  = mstream.pop_front() ? 0 : 1;
      need = 1;
    end else begin
      m = 0;
      while (!err) begin
        b = mstream.pop_front();
        need++;
        if (b) break;
        m++;
        if (m == OUT_W) err = 1;
      end
      if (err) begin
        val = 0;
        lat = need;
      end else begin
        info = 0;
        for (int i = 0; i < m; i++) info = info * 2 + int'(mstream.pop_front());
        need += m;
        code = (1 << m) - 1 + info;
        lat  = 2 * m + 1;
        if (mode == 2'b01)
          val = (code % 2 == 1) ? (code + 1) / 2 : ((-(code / 2)) & 32'hFFFF);
        else
          val = code;
      end
    end
  endtask

  task automatic do_req(input logic [1:0] mode, input int len, input string tag, input bit hold);
    int ev, elat, need, lat, avail;
    bit eerr;
    logic [15:0] held;
    model_decode(mode, len, ev, eerr, need, elat);
    avail = pushed_bits - consumed_bits;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_mode = mode; req_len = len[4:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      step_pump();
      lat++;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), ev);
    chk({tag, ".err"}, 32'(out_err), 32'(eerr));
    if (avail >= need) chk({tag, ".latency"}, lat, elat);
    if (hold) begin
      held = out_data;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_data"}, 32'(out_data), 32'(held));
        chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    consumed_bits += need;
    chk({tag, ".valid_clr"}, 32'(out_valid), 32'd0);
    chk({tag, ".fill"}, 32'(fill_level), pushed_bits - consumed_bits);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    src.delete(); mstream.delete();
    pushed_bits = 0; consumed_bits = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int ev, elat, need, lat;
    bit eerr;
    logic [15:0] w;
    logic [1:0]  md;
    int          ln;

    reset_n = 1'b0; in_data = '0; in_valid = 1'b0;
    req_valid = 1'b0; req_mode = '0; req_len = '0; out_ready = 1'b0;
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.fill", 32'(fill_level), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    do_reset();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.req_ready", 32'(req_ready), 32'd1);

    // ue basic
    add_word(16'hA000, 1); drain();
    chk("ue.fill0", 32'(fill_level), 32'd16);
    do_req(2'b00, 0, "ue0", 0);
    do_req(2'b00, 0, "ue1", 0);
    chk("ue.fill_end", 32'(fill_level), 32'd12);

    // se
    do_reset();
    add_word(16'h2140, 1); drain();
    do_req(2'b01, 0, "se_pos", 0);
    do_req(2'b01, 0, "se_neg", 0);
    chk("se.fill_end", 32'(fill_level), 32'd6);

    // u(n)
    do_reset();
    add_word(16'hABCD, 1); drain();
    do_req(2'b11, 0, "u0", 0);
    chk("u0.fill", 32'(fill_level), 32'd16);
    do_req(2'b11, 12, "u12", 0);
    chk("u12.fill", 32'(fill_level), 32'd4);

    // te
    do_reset();
    add_word(16'h4000, 1); drain();
    do_req(2'b10, 1, "te1", 0);
    do_req(2'b10, 3, "te3", 0);

    // stall on empty buffer, then leading-zero overflow
    do_reset();
    add_word(16'h0000, 0); add_word(16'h0000, 0);
    model_decode(2'b00, 0, ev, eerr, need, elat);
    req_valid = 1'b1; req_mode = 2'b00; req_len = '0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall.busy", 32'(busy), 32'd1);
    chk("stall.fill", 32'(fill_level), 32'd0);
    chk("stall.out_valid", 32'(out_valid), 32'd0);
    src.push_back(16'h0000); src.push_back(16'h0000);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step_pump();
      lat++;
    end
    chk("lzerr.out_valid", 32'(out_valid), 32'd1);
    chk("lzerr.err", 32'(out_err), 32'd1);
    chk("lzerr.model_err", 32'(out_err), 32'(eerr));
    chk("lzerr.data", 32'(out_data), 32'd0);
    chk("lzerr.fill", 32'(fill_level), 32'd16);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // backpressure, then async reset mid-LZ
    do_reset();
    add_word(16'h4000, 1); drain();
    do_req(2'b00, 0, "bp", 1);
    chk("bp.data_kept", 32'(out_data), 32'd1);
    req_valid = 1'b1; req_mode = 2'b00; req_len = '0;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("midlz.busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.fill", 32'(fill_level), 32'd0);
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data", 32'(out_data), 32'd0);
    chk("arst.out_err", 32'(out_err), 32'd0);
    do_reset();
    chk("arst.req_ready", 32'(req_ready), 32'd1);

    // randomized elements against the reference model
    for (int k = 0; k < 80; k++) begin
      while (mstream.size() < 48) begin
        w = 16'($urandom() | $urandom());
        if ($urandom_range(0, 7) == 0) w = 16'($urandom() & $urandom() & $urandom());
        add_word(w, 1);
      end
      md = 2'($urandom_range(0, 3));
      ln = (md == 2'b11) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      do_req(md, ln, $sformatf("rnd%0d", k), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
